// File: rtl/pattern_pkg.sv
// Shared constants for the VGA test-pattern source: palette, mode codes, stripe/band geometry.
// Also holds the divider-free band index helper used by the pattern mux.
package pattern_pkg;

    localparam logic [23:0] P0 = 24'hFF0000;
    localparam logic [23:0] P1 = 24'h00FF00;
    localparam logic [23:0] P2 = 24'h0000FF;
    localparam logic [23:0] P3 = 24'hFFFF00;
    localparam logic [23:0] P4 = 24'h00FFFF;
    localparam logic [23:0] P5 = 24'hFF00FF;
    localparam logic [23:0] P6 = 24'hFFFFFF;
    localparam logic [23:0] P7 = 24'h000000;

    localparam logic [1:0] MODE_VBAR   = 2'd0;
    localparam logic [1:0] MODE_HBAND  = 2'd1;
    localparam logic [1:0] MODE_CHECK  = 2'd2;
    localparam logic [1:0] MODE_SCROLL = 2'd3;

    localparam int STRIPE_W = 80;
    localparam int BAND_W   = 60;

    localparam logic [10:0] VBAR_SPLIT0 = 11'd200;
    localparam logic [10:0] VBAR_SPLIT1 = 11'd400;

    function automatic logic [23:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    palette = P0;
            3'd1:    palette = P1;
            3'd2:    palette = P2;
            3'd3:    palette = P3;
            3'd4:    palette = P4;
            3'd5:    palette = P5;
            3'd6:    palette = P6;
            default: palette = P7;
        endcase
    endfunction

    // x / w for x < 8*w, built as a chain of constant compares
    function automatic logic [2:0] band_index(input logic [10:0] x, input int w);
        band_index = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (x >= 11'(i * w)) band_index = 3'(i);
        end
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, rising-edge pulse.
// press fires 2 + DEBOUNCE cycles after a stable key change; no backpressure.
module key_debounce #(
    parameter int DEBOUNCE = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= key;
            sync2   <= sync1;
            level_q <= level;
            // any sample agreeing with the current level restarts the stability count
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/pattern_gen.sv
// Animated VGA test-pattern source: four patterns, button-advanced at frame boundaries.
// data is registered 1 clk after h_addr/v_addr; free-running, no backpressure.
module pattern_gen
    import pattern_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int SPEED    = 4,
    parameter int DEBOUNCE = 250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  h_addr,
    input  logic [9:0]  v_addr,
    input  logic        key,
    output logic [23:0] data,
    output logic [1:0]  mode,
    output logic        frame_tick
);
    localparam logic [10:0] H_MAX = 11'(H_ACTIVE);
    localparam logic [10:0] V_MAX = 11'(V_ACTIVE);
    localparam logic [10:0] STEP  = 11'(SPEED);

    logic        press;
    logic        pending;
    logic [9:0]  ofs;
    logic        at_end;
    logic        at_end_q;
    logic        eof;
    logic [10:0] h_w;
    logic [10:0] v_w;
    logic [10:0] ofs_sum;
    logic [10:0] ofs_next;
    logic [10:0] scroll_sum;
    logic [10:0] scroll_pos;
    logic [23:0] pixel;

    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key (
        .clk   (clk),
        .reset (reset),
        .key   (key),
        .press (press)
    );

    assign h_w = {1'b0, h_addr};
    assign v_w = {1'b0, v_addr};

    // a controller parked on the last pixel must not retrigger every cycle
    assign at_end = (h_w == H_MAX - 11'd1) && (v_w == V_MAX - 11'd1);
    assign eof    = at_end & ~at_end_q;

    assign ofs_sum  = {1'b0, ofs} + STEP;
    assign ofs_next = (ofs_sum >= H_MAX) ? ofs_sum - H_MAX : ofs_sum;

    assign scroll_sum = h_w + {1'b0, ofs};
    assign scroll_pos = (scroll_sum >= H_MAX) ? scroll_sum - H_MAX : scroll_sum;

    always_comb begin
        pixel = P7;
        if (h_w < H_MAX && v_w < V_MAX) begin
            case (mode)
                MODE_VBAR: begin
                    if (h_w <= VBAR_SPLIT0)      pixel = P0;
                    else if (h_w <= VBAR_SPLIT1) pixel = P1;
                    else                         pixel = P2;
                end
                MODE_HBAND: pixel = palette(band_index(v_w, BAND_W));
                MODE_CHECK: pixel = (h_addr[5] ^ v_addr[5]) ? P6 : P7;
                default:    pixel = palette(band_index(scroll_pos, STRIPE_W));
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data       <= '0;
            mode       <= MODE_VBAR;
            frame_tick <= 1'b0;
            ofs        <= '0;
            pending    <= 1'b0;
            at_end_q   <= 1'b0;
        end else begin
            data       <= pixel;
            frame_tick <= eof;
            at_end_q   <= at_end;
            // a press landing on the consuming eof re-arms the request for the next frame
            pending    <= press | (pending & ~eof);
            if (eof) begin
                if (pending) begin
                    mode <= mode + 2'd1;
                    ofs  <= '0;
                end else if (mode == MODE_SCROLL) begin
                    ofs <= ofs_next[9:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// Directed + randomized check of pattern_gen against a behavioural frame/pixel model.
module tb_pattern_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic        key;
    logic [23:0] data;
    logic [1:0]  mode;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    int m_mode = 0;
    int m_ofs  = 0;
    int m_pend = 0;

    logic [23:0] pal [8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
                             24'h00FFFF, 24'hFF00FF, 24'hFFFFFF, 24'h000000};

    pattern_gen #(
        .H_ACTIVE (640),
        .V_ACTIVE (480),
        .SPEED    (4),
        .DEBOUNCE (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .h_addr     (h_addr),
        .v_addr     (v_addr),
        .key        (key),
        .data       (data),
        .mode       (mode),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] ref_pix(input int h, input int v, input int m, input int o);
        if (h >= 640 || v >= 480) return 24'h000000;
        case (m)
            0:       return (h <= 200) ? 24'hFF0000 : (h <= 400) ? 24'h00FF00 : 24'h0000FF;
            1:       return pal[v / 60];
            2:       return (((h / 32) + (v / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
            default: return pal[((h + o) % 640) / 80];
        endcase
    endfunction

    task automatic pixel_at(input string tag, input int h, input int v);
        h_addr = 10'(h);
        v_addr = 10'(v);
        tick();
        check(tag, data, ref_pix(h, v, m_mode, m_ofs));
    endtask

    task automatic rand_pixels(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            int h;
            int v;
            h = int'($urandom_range(0, 700));
            v = int'($urandom_range(0, 520));
            if (h == 639 && v == 479) v = 0;
            pixel_at(tag, h, v);
        end
    endtask

    // full debounced press and release; the model registers one pending request
    task automatic press_key();
        key = 1'b1;
        repeat (22) tick();
        key = 1'b0;
        repeat (22) tick();
        m_pend = 1;
    endtask

    task automatic model_eof();
        if (m_pend != 0) begin
            m_mode = (m_mode + 1) % 4;
            m_ofs  = 0;
            m_pend = 0;
        end else if (m_mode == 3) begin
            m_ofs = (m_ofs + 4) % 640;
        end
    endtask

    task automatic do_frame(input int hold);
        h_addr = 10'd639;
        v_addr = 10'd479;
        tick();
        check("frame_tick_pulse", {23'd0, frame_tick}, 24'd1);
        model_eof();
        check("mode_after_eof", {22'd0, mode}, 24'(m_mode));
        for (int i = 1; i < hold; i++) begin
            tick();
            check("frame_tick_held", {23'd0, frame_tick}, 24'd0);
        end
        h_addr = 10'd0;
        v_addr = 10'd0;
        tick();
        check("frame_tick_low", {23'd0, frame_tick}, 24'd0);
    endtask

    initial begin
        reset  = 1'b1;
        key    = 1'b0;
        h_addr = 10'd0;
        v_addr = 10'd0;
        repeat (3) tick();
        check("reset_data", data, 24'h000000);
        check("reset_mode", {22'd0, mode}, 24'd0);
        check("reset_tick", {23'd0, frame_tick}, 24'd0);
        reset = 1'b0;

        // mode 0 bar boundary and blanking
        pixel_at("vbar_h200", 200, 10);
        check("vbar_h200_red", data, 24'hFF0000);
        pixel_at("vbar_h201", 201, 10);
        check("vbar_h201_green", data, 24'h00FF00);
        pixel_at("vbar_h640", 640, 10);
        check("vbar_h640_black", data, 24'h000000);
        rand_pixels("rand_mode0", 40);

        // bouncing key must never settle
        h_addr = 10'd640;
        v_addr = 10'd0;
        for (int i = 0; i < 100; i++) begin
            key = ((i / 5) % 2) == 1;
            tick();
        end
        check("bounce_no_pending", {23'd0, dut.pending}, 24'd0);
        key = 1'b1;
        repeat (20) tick();
        check("hold_pending", {23'd0, dut.pending}, 24'd1);
        check("hold_mode_still0", {22'd0, mode}, 24'd0);
        key = 1'b0;
        repeat (22) tick();
        m_pend = 1;

        do_frame(1);
        pixel_at("hband_v65", 0, 65);
        check("hband_v65_green", data, 24'h00FF00);
        rand_pixels("rand_mode1", 40);

        press_key();
        do_frame(3);
        rand_pixels("rand_mode2", 40);

        press_key();
        do_frame(1);
        rand_pixels("rand_mode3_ofs0", 30);

        for (int f = 1; f <= 160; f++) begin
            do_frame(1);
            if (f == 20) begin
                pixel_at("scroll_f20_h0", 0, 0);
                check("scroll_f20_p1", data, 24'h00FF00);
                pixel_at("scroll_f20_wrap", 600, 100);
                check("scroll_f20_wrap_p0", data, 24'hFF0000);
            end
            if (f % 8 == 3) rand_pixels("rand_scroll", 2);
        end
        check("scroll_ofs_wrapped", {14'd0, dut.ofs}, 24'd0);
        pixel_at("scroll_f160_h0", 0, 0);
        check("scroll_f160_p0", data, 24'hFF0000);

        // press lands exactly on the eof that consumes an older request
        press_key();
        key    = 1'b1;
        h_addr = 10'd100;
        v_addr = 10'd100;
        repeat (18) tick();
        h_addr = 10'd639;
        v_addr = 10'd479;
        tick();
        check("sim_frame_tick", {23'd0, frame_tick}, 24'd1);
        model_eof();
        m_pend = 1;
        check("sim_mode_step1", {22'd0, mode}, 24'(m_mode));
        check("sim_pending_kept", {23'd0, dut.pending}, 24'd1);
        h_addr = 10'd0;
        v_addr = 10'd0;
        key    = 1'b0;
        repeat (22) tick();
        do_frame(1);
        check("sim_mode_step2", {22'd0, mode}, 24'd1);

        // two presses in one frame give one step
        press_key();
        press_key();
        do_frame(1);
        do_frame(1);
        check("multi_press_one_step", {22'd0, mode}, 24'd2);

        pixel_at("check_before_reset", 40, 0);
        check("check_white", data, 24'hFFFFFF);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_data", data, 24'h000000);
        check("async_reset_mode", {22'd0, mode}, 24'd0);
        m_mode = 0;
        m_ofs  = 0;
        m_pend = 0;
        tick();
        reset = 1'b0;
        tick();
        do_frame(1);
        rand_pixels("rand_after_reset", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_gen.md
# pattern_gen

Animated test-pattern source for the VGA path. It runs on the 25 MHz pixel clock and takes the current scan coordinates from the VGA controller. It returns one registered 24-bit RGB word per pixel, selected from four patterns. A debounced push-button advances the pattern, and the change takes effect only at a frame boundary. It replaces the fixed stripe generator as the pixel-data feed of the VGA controller.

## Interface
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines per frame.
- `SPEED`, 4: scroll step in pixels per frame for mode 3; legal range 1..H_ACTIVE-1.
- `DEBOUNCE`, 250000: stable cycles required on `key` (10 ms at 25 MHz).
- `clk` in 1: pixel clock (vga_clk, 25 MHz).
- `reset` in 1: asynchronous, active-high.
- `h_addr` in 10: current column from the VGA controller.
- `v_addr` in 10: current line from the VGA controller.
- `key` in 1: raw push-button, active-high, asynchronous to `clk`.
- `data` out 24: RGB pixel, {R[7:0],G[7:0],B[7:0]}.
- `mode` out 2: active pattern.
- `frame_tick` out 1: one-cycle pulse per frame.

## Operation
Reset values:
- `data`=0, `mode`=0, `frame_tick`=0.
- Scroll offset `ofs`=0, `pending`=0, debounce state cleared.

Palette P[0..7]: FF0000, 00FF00, 0000FF, FFFF00, 00FFFF, FF00FF, FFFFFF, 000000.

Pattern functions of (h,v, ofs):
- Mode 0, vertical bars: h<=200 → FF0000; h<=400 → 00FF00; else 0000FF.
- Mode 1, horizontal bands: P[v/60], eight bands of 60 lines. Compare chain; no divider.
- Mode 2, checkerboard: (h[5]^v[5]) ? FFFFFF : 000000, giving 32×32 squares.
- Mode 3, scrolling bars:
  - s = h+ofs; if s>=H_ACTIVE then s-=H_ACTIVE.
  - Output P[s/80], with s/80 done by compare chain.
- Any mode with h>=H_ACTIVE or v>=V_ACTIVE → 000000.

End-of-frame detection:
- `eof` = (h_addr==H_ACTIVE-1 && v_addr==V_ACTIVE-1) this cycle, and not the same coordinates last cycle.
- A held coordinate fires once only.

On the `eof` cycle edge:
- If `pending`: `mode`<=mode+1 (3 wraps to 0), `pending`<=0, `ofs`<=0.
- Else if mode==3: `ofs`<=ofs+SPEED, minus H_ACTIVE on overflow. Width is 10 bits; the sum is computed in 11 bits.
- Else `ofs` holds.

Key path:
- Two-flop synchronizer feeds a stability counter.
- The debounced level updates after DEBOUNCE consecutive equal samples.
- A rising edge of the debounced level is `press`.
- `press` sets `pending`.
- Several presses within one frame advance `mode` by one step only.
- `press` on the same cycle as `eof`:
  - If `pending` was already set: that eof consumes the old request. `pending` stays 1, so the next eof advances again.
  - If `pending` was 0: it becomes 1 and applies at the next eof.

Reset mid-frame returns the block to mode 0 immediately. The first `eof` after reset is detected normally.

## Timing
- `data` is registered: latency is exactly 1 clk from `h_addr`/`v_addr`.
- The mode or ofs used for a pixel is the value held before the clock edge that registers it.
- `frame_tick` is high for exactly 1 clk, the cycle after `eof` is sampled.
- `mode` and `ofs` update on that same edge, so all pixels of the next frame use the new values.
- Key-to-pending latency: 2 sync cycles + DEBOUNCE cycles + 1 edge-detect cycle.
- No combinational path from `key` to any output.

## Structure
- Package `pattern_pkg`:
  - palette constants P0..P7;
  - mode encodings MODE_VBAR=0, MODE_HBAND=1, MODE_CHECK=2, MODE_SCROLL=3;
  - stripe and band width constants 80 and 60.
- Sub-module `key_debounce` (synchronizer + counter + rising-edge pulse), parameter DEBOUNCE. Instantiate once.
- Everything else lives in `pattern_gen`: eof detect, mode/pending/ofs registers, pattern mux, output register.

## Test plan
- Reset then mode 0: drive h=200,v=10 then h=201 → `data` FF0000 then 00FF00, each one clk later. Drive h=640 → 000000.
- Debounce: `key` bounces at 5-cycle intervals for 100 cycles, with DEBOUNCE=16 → no `pending`. Hold high for 20 cycles → `pending`=1. `mode` is still 0 until eof.
- Frame boundary: after a press, sweep to (639,479) → `frame_tick` pulses once and `mode`=1. Then h=0,v=65 → `data` 00FF00 (band 1).
- Scroll wrap: mode 3, SPEED=4, run 160 frames.
  - At frame 20, h=0 → `ofs`=80 → P1.
  - At frame 160, `ofs` returns to 0 (640 mod 640).
- Simultaneous press and eof with `pending`=1 → mode advances at this eof and again at the next.
- Async reset asserted mid-line in mode 2 → `data`=0 and `mode`=0 immediately, with no clock edge required.
